// File: rtl/full_handshake_rx_fifo_if.sv
// full_handshake_rx_fifo_if: upstream four-phase and downstream
// valid/ready signals of the receive FIFO, grouped as one bundle.
interface full_handshake_rx_fifo_if #(
    parameter int DATA_WIDTH = 40,
    parameter int CNT_WIDTH  = 3
);
    logic                  i_vld;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_rdy;
    logic                  o_vld;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  i_rdy;
    logic [CNT_WIDTH-1:0]  o_level;

    modport slave (
        input  i_vld, i_data, i_rdy,
        output o_rdy, o_vld, o_data, o_level
    );

    modport master (
        output i_vld, i_data, i_rdy,
        input  o_rdy, o_vld, o_data, o_level
    );
endinterface

// File: rtl/full_handshake_rx_fifo.sv
// full_handshake_rx_fifo: four-phase CDC receiver into a FWFT FIFO.
// Optional counters: define FULL_HANDSHAKE_RX_FIFO_STATS_EN.
module full_handshake_rx_fifo #(
    parameter int DATA_WIDTH  = 40,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CNT_WIDTH   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic clk,
    input  logic rst_n,
    full_handshake_rx_fifo_if.slave bus
`ifdef FULL_HANDSHAKE_RX_FIFO_STATS_EN
    ,
    output logic [15:0] o_xfer_cnt,
    output logic [15:0] o_stall_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        STALL = 3'b010,
        ACK   = 3'b100
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rdy;
    logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_WIDTH-1:0]   r_count;

    logic w_vld_s;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_vld_s = r_sync[SYNC_STAGES-1];
    assign w_full  = (r_count == CNT_WIDTH'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && bus.i_rdy;
    // Full is judged on the registered count, so a same-cycle pop
    // never frees a slot for the push; STALL retries next cycle.
    assign w_push  = ((r_state == IDLE) || (r_state == STALL))
                     && w_vld_s && !w_full;

    // Only the request level crosses domains; data is quasi-static.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.i_vld};
        end
    end

    // Handshake FSM: one push per request phase, ack held until release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rdy   <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_vld_s) begin
                        if (!w_full) begin
                            r_state <= ACK;
                            r_rdy   <= 1'b1;
                        end else begin
                            r_state <= STALL;
                        end
                    end
                end
                STALL: begin
                    if (!w_vld_s) begin
                        r_state <= IDLE;
                    end else if (!w_full) begin
                        r_state <= ACK;
                        r_rdy   <= 1'b1;
                    end
                end
                ACK: begin
                    if (!w_vld_s) begin
                        r_state <= IDLE;
                        r_rdy   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    // Storage cleared on reset so the stale head is deterministic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= bus.i_data;
        end
    end

    // Pointers wrap naturally; count tracks push minus pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_rdy   = r_rdy;
    assign bus.o_vld   = !w_empty;
    assign bus.o_data  = r_mem[r_rd_ptr];
    assign bus.o_level = r_count;

`ifdef FULL_HANDSHAKE_RX_FIFO_STATS_EN
    logic [15:0] r_xfer_cnt;
    logic [15:0] r_stall_cnt;

    // Transfer count wraps; stall cycle count saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xfer_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                r_xfer_cnt <= r_xfer_cnt + 16'd1;
            end
            if ((r_state == STALL) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign o_xfer_cnt  = r_xfer_cnt;
    assign o_stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_full_handshake_rx_fifo.sv
// tb_full_handshake_rx_fifo: directed + random four-phase transfers
// checked against a queue model of the buffered words.
module tb_full_handshake_rx_fifo;
    localparam int DW = 40;
    localparam int SS = 2;
    localparam int FD = 4;
    localparam int CW = $clog2(FD) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    full_handshake_rx_fifo_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus();

`ifdef FULL_HANDSHAKE_RX_FIFO_STATS_EN
    logic [15:0] xfer_cnt;
    logic [15:0] stall_cnt;
`endif

    full_handshake_rx_fifo #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS),
        .FIFO_DEPTH (FD),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef FULL_HANDSHAKE_RX_FIFO_STATS_EN
        ,
        .o_xfer_cnt (xfer_cnt),
        .o_stall_cnt(stall_cnt)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_pop  = 0;
    int n_sent = 0;
    bit rnd    = 1'b0;

    logic [DW-1:0] tx_data = '0;
    logic [DW-1:0] q[$];
    bit            pop_ev;
    logic          prev_rdy = 1'b0;

    task automatic check(input string tag, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference: words enter in transmit order when the ack rises,
    // leave in the same order whenever the head is offered and taken.
    initial begin
        forever begin
            @(posedge clk);
            pop_ev = rst_n && (q.size() != 0) && bus.i_rdy;
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                prev_rdy = 1'b0;
            end else begin
                if (pop_ev) begin
                    void'(q.pop_front());
                    n_pop++;
                end
                if (bus.o_rdy && !prev_rdy) begin
                    check("ack_not_full", 64'(q.size() < FD), 64'd1);
                    q.push_back(tx_data);
                end
                prev_rdy = bus.o_rdy;
                check("level", 64'(bus.o_level), 64'(q.size()));
                check("level_max", 64'(bus.o_level <= CW'(FD)), 64'd1);
                check("vld", 64'(bus.o_vld), 64'(q.size() != 0));
                if (q.size() != 0) begin
                    check("head", 64'(bus.o_data), 64'(q[0]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (rnd) begin
            bus.i_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic raise(input logic [DW-1:0] d, output int lat);
        bit ok;
        tx_data    = d;
        bus.i_data = d;
        bus.i_vld  = 1'b1;
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            lat++;
            if (bus.o_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic drop(output int lat);
        bit ok;
        bus.i_vld = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 300; k++) begin
            step();
            lat++;
            if (!bus.o_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drop_timeout", 64'd0, 64'd1);
    endtask

    task automatic xfer(input logic [DW-1:0] d, input bit chk_lat);
        int lat;
        raise(d, lat);
        if (chk_lat) check("ack_lat", 64'(lat), 64'(SS + 1));
        drop(lat);
        if (chk_lat) check("drop_lat", 64'(lat), 64'(SS + 1));
        n_sent++;
    endtask

    task automatic drain();
        bus.i_rdy = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (q.size() == 0) break;
            step();
        end
        check("drain_empty", 64'(q.size()), 64'd0);
        bus.i_rdy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        step();
        #2 rst_n = 1'b1;
        step();
    endtask

    localparam int WAIT = 8;

    initial begin
        int lat;
        bus.i_vld  = 1'b0;
        bus.i_data = '0;
        bus.i_rdy  = 1'b0;
        #1;
        check("rst_rdy", 64'(bus.o_rdy), 64'd0);
        check("rst_vld", 64'(bus.o_vld), 64'd0);
        check("rst_data", 64'(bus.o_data), 64'd0);
        check("rst_level", 64'(bus.o_level), 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // single word, consumer ready
        bus.i_rdy = 1'b1;
        raise(40'h12_3456_789A, lat);
        check("s1_lat", 64'(lat), 64'(SS + 1));
        check("s1_vld", 64'(bus.o_vld), 64'd1);
        check("s1_data", 64'(bus.o_data), 64'h12_3456_789A);
        step();
        check("s1_vld_fall", 64'(bus.o_vld), 64'd0);
        drop(lat);
        check("s1_drop_lat", 64'(lat), 64'(SS + 1));
        check("s1_level", 64'(bus.o_level), 64'd0);
        bus.i_rdy = 1'b0;

        // backpressure fill and stall
        do_reset();
        for (int d = 1; d <= 4; d++) xfer(DW'(d), 1'b1);
        check("s2_full", 64'(bus.o_level), 64'(FD));
        tx_data    = DW'(5);
        bus.i_data = DW'(5);
        bus.i_vld  = 1'b1;
        for (int k = 0; k < WAIT; k++) begin
            step();
            check("s2_stall_rdy", 64'(bus.o_rdy), 64'd0);
        end
        bus.i_rdy = 1'b1;
        step();
        bus.i_rdy = 1'b0;
        check("s2_pop_no_ack", 64'(bus.o_rdy), 64'd0);
        check("s2_pop_level", 64'(bus.o_level), 64'(FD - 1));
        check("s2_head", 64'(bus.o_data), 64'd2);
        step();
        check("s2_late_ack", 64'(bus.o_rdy), 64'd1);
        check("s2_refull", 64'(bus.o_level), 64'(FD));
`ifdef FULL_HANDSHAKE_RX_FIFO_STATS_EN
        check("s6_xfer", 64'(xfer_cnt), 64'd5);
        check("s6_stall", 64'(stall_cnt), 64'(WAIT + 2 - (SS + 1)));
`endif
        drop(lat);
        drain();

        // simultaneous push and pop at level 2
        xfer(DW'(11), 1'b1);
        xfer(DW'(12), 1'b1);
        tx_data    = DW'(13);
        bus.i_data = DW'(13);
        bus.i_vld  = 1'b1;
        step();
        step();
        bus.i_rdy = 1'b1;
        step();
        bus.i_rdy = 1'b0;
        check("s4_ack", 64'(bus.o_rdy), 64'd1);
        check("s4_level", 64'(bus.o_level), 64'd2);
        check("s4_head", 64'(bus.o_data), 64'd12);
        drop(lat);
        drain();

        // reset while acking with three words buffered
        xfer(DW'(21), 1'b1);
        xfer(DW'(22), 1'b1);
        raise(DW'(23), lat);
        check("s5_level_pre", 64'(bus.o_level), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check("s5_rdy", 64'(bus.o_rdy), 64'd0);
        check("s5_vld", 64'(bus.o_vld), 64'd0);
        check("s5_level", 64'(bus.o_level), 64'd0);
        @(negedge clk);
        tx_data    = DW'(24);
        bus.i_data = DW'(24);
        #2 rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            lat++;
            if (bus.o_rdy) break;
        end
        check("s5_reack_lat", 64'(lat), 64'(SS + 1));
        drop(lat);
        drain();

        // random traffic with random consumer readiness
        n_pop  = 0;
        n_sent = 0;
        rnd    = 1'b1;
        for (int t = 0; t < 30; t++) begin
            repeat ($urandom_range(0, 3)) step();
            xfer({$urandom, $urandom}, 1'b0);
        end
        rnd = 1'b0;
        drain();
        check("rnd_delivered", 64'(n_pop), 64'(n_sent));
        check("rnd_level", 64'(bus.o_level), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/full_handshake_rx_fifo.md
Name: full_handshake_rx_fifo

Overview:
- Next-generation receive side of the four-phase clock-domain-crossing handshake used by the debug path.
- The transmitter asserts i_vld with i_data held stable, and this block acknowledges with o_rdy. The transmitter then drops i_vld, and this block drops o_rdy.
- Unlike the single-word receiver, captured words go into a parametrised FIFO and drain over a valid/ready interface, so downstream backpressure is absorbed.
- The synchroniser depth is configurable.
- When the FIFO is full, the acknowledge is withheld rather than data being dropped.

Parameters:
- DATA_WIDTH, 40, width of i_data / o_data.
- SYNC_STAGES, 2, flops in the i_vld synchroniser chain. Legal range 2..4.
- FIFO_DEPTH, 4, number of buffered words. Power of two, 2..16.
- CNT_WIDTH, $clog2(FIFO_DEPTH)+1, width of o_level.

Ports:
- clk  in  1  receive-domain clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- i_vld  in  1  request from the transmitter domain (asynchronous to clk).
- i_data  in  DATA_WIDTH  payload; held stable by the transmitter while i_vld is high.
- o_rdy  out  1  acknowledge back to the transmitter (level, four-phase).
- o_vld  out  1  downstream data valid.
- o_data  out  DATA_WIDTH  downstream data (FIFO head).
- i_rdy  in  1  downstream ready.
- o_level  out  CNT_WIDTH  current FIFO occupancy.

Behaviour:
- Reset: one clock, clk. rst_n is asynchronous and active-low.
  - All flops clear immediately: synchroniser chain, state=IDLE, FIFO pointers/count = 0.
  - Outputs: o_rdy=0, o_vld=0, o_data=0, o_level=0.
  - Reset mid-transfer discards all buffered words and any pending ack.
  - After release, a transmitter still holding i_vld=1 is treated as a new request.
- Synchroniser:
  - vld_s is i_vld after SYNC_STAGES clk flops.
  - Only i_vld crosses domains. i_data is sampled directly, which is legal because it is stable while i_vld is high.
- FSM (one-hot, 3 states):
  - IDLE: if vld_s=1 and count<FIFO_DEPTH, push i_data, set o_rdy=1 and go to ACK. If vld_s=1 and FIFO is full, go to STALL. Otherwise stay in IDLE.
  - STALL: o_rdy stays 0. When count<FIFO_DEPTH, push i_data, set o_rdy=1 and go to ACK. If vld_s falls while in STALL (protocol violation), return to IDLE without pushing.
  - ACK: o_rdy held at 1. When vld_s=0, clear o_rdy and go to IDLE.
  - Exactly one push per i_vld high phase.
- Push timing:
  - The push is registered: the word appears in the FIFO and o_rdy rises on the same clk edge.
  - Latency from i_vld rising (first sampling edge) to o_rdy=1 is SYNC_STAGES+1 clk edges.
  - o_vld rises on that same edge if the FIFO was empty.
- FIFO:
  - First-word fall-through: o_vld = (count!=0), o_data = mem[rd_ptr].
  - Pop on o_vld && i_rdy.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - count/o_level is a registered up/down counter.
  - Push and pop in the same cycle: both occur and count is unchanged.
  - Full test uses the registered count only. A pop in the same cycle does not enable a push; the push is taken the next cycle from STALL.
  - Empty with i_rdy=1 leaves state unchanged. o_data while empty is don't-care but must be deterministic (stale head).
- Invariants:
  - o_level never exceeds FIFO_DEPTH.
  - o_rdy never rises while count==FIFO_DEPTH before the push.
  - No word is ever overwritten or dropped.

Optional Feature:
- Macro: FULL_HANDSHAKE_RX_FIFO_STATS_EN.
- When defined, add two output ports:
  - o_xfer_cnt (16 bits): increments on every push and wraps 0xFFFF->0.
  - o_stall_cnt (16 bits): increments every clk cycle spent in STALL and saturates at 0xFFFF.
  - Both counters clear on rst_n.
- When not defined, neither port nor its logic exists, and behaviour is otherwise identical.

Test Plan:
1. Single word, SYNC_STAGES=2: transmitter drives i_data=40'h12_3456_789A with i_vld=1, i_rdy=1 -> o_rdy=1 and o_vld=1 with o_data=40'h12_3456_789A on edge 3. o_vld falls next cycle. Drop i_vld -> o_rdy=0 three edges later. o_level returns to 0.
2. Backpressure fill, FIFO_DEPTH=4, i_rdy=0, five four-phase transfers of data 1..5 -> first four acked, o_level=4. Fifth request holds o_rdy=0 in STALL. Raise i_rdy for one cycle -> pop data 1, then the fifth is pushed and acked the next cycle. Drain order is 2,3,4,5.
3. Pointer wrap: 10 sequential transfers with i_rdy toggling 1/0 -> output sequence is exactly the 10 inputs in order, and o_level is never above 4.
4. Simultaneous push/pop at level 2 -> o_level stays 2 and the head advances.
5. Reset mid-operation: assert rst_n low during ACK with o_level=3 -> o_rdy, o_vld and o_level are all 0 immediately, before the next clk edge. Release with i_vld still 1 -> a new ack after SYNC_STAGES+1 edges.
6. With FULL_HANDSHAKE_RX_FIFO_STATS_EN defined, run scenario 2 -> o_xfer_cnt=5 and o_stall_cnt equals the cycles spent in STALL (at least 1).
